// File: rtl/core_pkg.sv
// Shared core types for the data-memory arbiter.
//   Xlen        : data/address width
//   MaskW       : byte-mask width (Xlen/8)
//   arb_state_e : arbiter FSM states
//   arb_owner_e : requester that owns the outstanding transaction
package core_pkg;

    localparam int unsigned Xlen  = 32;
    localparam int unsigned MaskW = Xlen / 8;

    typedef enum logic [1:0] {
        Idle     = 2'd0,
        Issue    = 2'd1,
        WaitResp = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnerIfu = 1'b0,
        OwnerLsu = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-input round-robin pick between IFU and LSU.
//   clk_i, rst_ni : clock, async active-low reset
//   req_ifu_i     : IFU requesting
//   req_lsu_i     : LSU requesting
//   update_i      : strobe, served_i becomes the last-served requester
//   served_i      : requester just served
//   gnt_valid_o   : at least one requester valid
//   gnt_o         : winner (combinational)
module mem_rr_arb
    import core_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_ifu_i,
    input  logic       req_lsu_i,
    input  logic       update_i,
    input  arb_owner_e served_i,
    output logic       gnt_valid_o,
    output arb_owner_e gnt_o
);

    arb_owner_e r_last;
    arb_owner_e w_last;

    always_comb begin
        // Bypass the strobe so a pick made in the same cycle as the update
        // already sees the new priority.
        w_last      = update_i ? served_i : r_last;
        gnt_valid_o = req_ifu_i | req_lsu_i;
        gnt_o       = OwnerIfu;
        if (req_ifu_i && req_lsu_i) begin
            gnt_o = (w_last == OwnerIfu) ? OwnerLsu : OwnerIfu;
        end else if (req_lsu_i) begin
            gnt_o = OwnerLsu;
        end
    end

    // Reset to IFU so the LSU wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last <= OwnerIfu;
        end else if (update_i) begin
            r_last <= served_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data-memory port between IFU and LSU. One transaction
// outstanding at a time; the winner's request is captured, issued on the
// memory valid/ready handshake, and the single response beat is routed back
// to the owner in the cycle it arrives.
//   clk_i, rst_ni        : clock, async active-low reset
//   ifu_*                : IFU request (read-only) and response
//   lsu_*                : LSU request (wmask 0 = read) and response
//   mem_*                : memory request (captured payload) and response
//   err_o                : sticky, response seen with nothing outstanding
module mem_arbiter
    import core_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ifu_valid_i,
    output logic             ifu_ready_o,
    input  logic [Xlen-1:0]  ifu_addr_i,
    output logic [Xlen-1:0]  ifu_rdata_o,
    output logic             ifu_rvalid_o,
    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [Xlen-1:0]  lsu_addr_i,
    input  logic [Xlen-1:0]  lsu_wdata_i,
    input  logic [MaskW-1:0] lsu_wmask_i,
    output logic [Xlen-1:0]  lsu_rdata_o,
    output logic             lsu_rvalid_o,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic [Xlen-1:0]  mem_addr_o,
    output logic [Xlen-1:0]  mem_wdata_o,
    output logic [MaskW-1:0] mem_wmask_o,
    input  logic [Xlen-1:0]  mem_rdata_i,
    input  logic             mem_rvalid_i,
    output logic             err_o
);

    arb_state_e       r_state;
    arb_owner_e       r_owner;
    logic [Xlen-1:0]  r_addr;
    logic [Xlen-1:0]  r_wdata;
    logic [MaskW-1:0] r_wmask;
    logic             r_err;

    logic             w_gnt_valid;
    arb_owner_e       w_gnt;
    logic             w_resp;
    logic             w_issue;
    logic [Xlen-1:0]  w_cap_addr;
    logic [Xlen-1:0]  w_cap_wdata;
    logic [MaskW-1:0] w_cap_wmask;

    assign w_resp  = (r_state == WaitResp) && mem_rvalid_i;
    assign w_issue = (r_state == Issue);

    mem_rr_arb u_rr_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_ifu_i   (ifu_valid_i),
        .req_lsu_i   (lsu_valid_i),
        .update_i    (w_resp),
        .served_i    (r_owner),
        .gnt_valid_o (w_gnt_valid),
        .gnt_o       (w_gnt)
    );

    // IFU is read-only: its write data and mask are forced to zero.
    always_comb begin
        w_cap_addr  = ifu_addr_i;
        w_cap_wdata = '0;
        w_cap_wmask = '0;
        if (w_gnt == OwnerLsu) begin
            w_cap_addr  = lsu_addr_i;
            w_cap_wdata = lsu_wdata_i;
            w_cap_wmask = lsu_wmask_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= Idle;
            r_owner <= OwnerIfu;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_err   <= 1'b0;
        end else begin
            if (mem_rvalid_i && (r_state != WaitResp)) begin
                r_err <= 1'b1;
            end
            unique case (r_state)
                Idle: begin
                    if (w_gnt_valid) begin
                        r_owner <= w_gnt;
                        r_addr  <= w_cap_addr;
                        r_wdata <= w_cap_wdata;
                        r_wmask <= w_cap_wmask;
                        r_state <= Issue;
                    end
                end
                Issue: begin
                    if (mem_ready_i) begin
                        r_state <= WaitResp;
                    end
                end
                WaitResp: begin
                    if (mem_rvalid_i) begin
                        // Re-arbitrate in the response cycle: no idle bubble.
                        if (w_gnt_valid) begin
                            r_owner <= w_gnt;
                            r_addr  <= w_cap_addr;
                            r_wdata <= w_cap_wdata;
                            r_wmask <= w_cap_wmask;
                            r_state <= Issue;
                        end else begin
                            r_state <= Idle;
                        end
                    end
                end
                default: r_state <= Idle;
            endcase
        end
    end

    always_comb begin
        mem_valid_o  = w_issue;
        mem_addr_o   = r_addr;
        mem_wdata_o  = r_wdata;
        mem_wmask_o  = r_wmask;
        ifu_ready_o  = w_issue && (r_owner == OwnerIfu) && mem_ready_i;
        lsu_ready_o  = w_issue && (r_owner == OwnerLsu) && mem_ready_i;
        ifu_rvalid_o = w_resp && (r_owner == OwnerIfu);
        lsu_rvalid_o = w_resp && (r_owner == OwnerLsu);
        ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
        lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
        err_o        = r_err;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ifu_valid_i = 1'b0;
    logic        ifu_ready_o;
    logic [31:0] ifu_addr_i = '0;
    logic [31:0] ifu_rdata_o;
    logic        ifu_rvalid_o;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic [3:0]  lsu_wmask_i = '0;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rvalid_o;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_rvalid_i = 1'b0;
    logic        err_o;

    int n_pass = 0;
    int n_total = 0;
    bit rand_on = 1'b0;
    bit rand_done = 1'b0;
    int mon_out = 0;
    logic [31:0] ifu_q[$];
    logic [31:0] lsu_q[$];

    always #5 clk_i = ~clk_i;

    mem_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ifu_valid_i  (ifu_valid_i),
        .ifu_ready_o  (ifu_ready_o),
        .ifu_addr_i   (ifu_addr_i),
        .ifu_rdata_o  (ifu_rdata_o),
        .ifu_rvalid_o (ifu_rvalid_o),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_wmask_i  (lsu_wmask_i),
        .lsu_rdata_o  (lsu_rdata_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .mem_valid_o  (mem_valid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rvalid_i (mem_rvalid_i),
        .err_o        (err_o)
    );

    function automatic void chk(input string name, input logic [159:0] act,
                                input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Memory contents model: response data derived from the request payload.
    function automatic logic [31:0] mem_resp(input logic [31:0] a, input logic [31:0] w,
                                             input logic [3:0] m);
        return (a * 32'd2654435761) ^ w ^ {28'h0, m};
    endfunction

    function automatic logic [159:0] all_outs();
        return {ifu_ready_o, ifu_rvalid_o, ifu_rdata_o, lsu_ready_o, lsu_rvalid_o,
                lsu_rdata_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o, err_o};
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        ifu_valid_i = 0; lsu_valid_i = 0; mem_ready_i = 0; mem_rvalid_i = 0;
        ifu_addr_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; lsu_wmask_i = 0; mem_rdata_i = 0;
        #1 chk("reset_outputs_zero", all_outs(), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic drive_ifu(input int count);
        int t;
        @(negedge clk_i);
        for (int n = 0; n < count; n++) begin
            int gap = $urandom_range(0, 2);
            if (gap != 0) begin
                ifu_valid_i = 1'b0;
                repeat (gap) @(negedge clk_i);
            end
            ifu_valid_i = 1'b1;
            ifu_addr_i = $urandom & 32'hFFFF_FFFC;
            t = 0;
            forever begin
                #1;
                if (ifu_ready_o) break;
                t++;
                if (t > 200) begin
                    chk("rnd_ifu_accept_timeout", ifu_ready_o, 1);
                    break;
                end
                @(negedge clk_i);
            end
            ifu_q.push_back(mem_resp(ifu_addr_i, 32'h0, 4'h0));
            @(negedge clk_i);
        end
        ifu_valid_i = 1'b0;
    endtask

    task automatic drive_lsu(input int count);
        int t;
        @(negedge clk_i);
        for (int n = 0; n < count; n++) begin
            int gap = $urandom_range(0, 2);
            if (gap != 0) begin
                lsu_valid_i = 1'b0;
                repeat (gap) @(negedge clk_i);
            end
            lsu_valid_i = 1'b1;
            lsu_addr_i = $urandom;
            lsu_wdata_i = $urandom;
            lsu_wmask_i = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            t = 0;
            forever begin
                #1;
                if (lsu_ready_o) break;
                t++;
                if (t > 200) begin
                    chk("rnd_lsu_accept_timeout", lsu_ready_o, 1);
                    break;
                end
                @(negedge clk_i);
            end
            lsu_q.push_back(mem_resp(lsu_addr_i, lsu_wdata_i, lsu_wmask_i));
            @(negedge clk_i);
        end
        lsu_valid_i = 1'b0;
    endtask

    // Memory: random ready, one response 1..3 cycles after each accept.
    task automatic mem_model();
        bit pend = 0;
        int cnt = 0;
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_mask;
        while (!rand_done) begin
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
            mem_rdata_i = '0;
            if (pend && cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = mem_resp(p_addr, p_wdata, p_mask);
                pend = 0;
            end else if (pend) begin
                cnt--;
            end
            mem_ready_i = ($urandom_range(0, 2) != 0);
            #1;
            if (mem_valid_o && mem_ready_i) begin
                pend = 1;
                cnt = $urandom_range(0, 2);
                p_addr = mem_addr_o;
                p_wdata = mem_wdata_o;
                p_mask = mem_wmask_o;
            end
        end
        mem_rvalid_i = 1'b0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
    endtask

    // Monitor / scoreboard for the random phase.
    always @(negedge clk_i) begin
        if (rand_on) begin
            #2;
            if (ifu_rvalid_o) begin
                if (ifu_q.size() == 0) chk("rnd_ifu_unexpected_rvalid", ifu_rvalid_o, 0);
                else chk("rnd_ifu_rdata", ifu_rdata_o, ifu_q.pop_front());
            end else begin
                chk("rnd_ifu_rdata_idle", ifu_rdata_o, 0);
            end
            if (lsu_rvalid_o) begin
                if (lsu_q.size() == 0) chk("rnd_lsu_unexpected_rvalid", lsu_rvalid_o, 0);
                else chk("rnd_lsu_rdata", lsu_rdata_o, lsu_q.pop_front());
            end else begin
                chk("rnd_lsu_rdata_idle", lsu_rdata_o, 0);
            end
            if (mem_rvalid_i && mon_out == 1)
                chk("rnd_one_rvalid", ifu_rvalid_o ^ lsu_rvalid_o, 1);
            if (mem_valid_o) chk("rnd_single_outstanding", mon_out, 0);
            if (mem_valid_o && mem_ready_i) begin
                chk("rnd_one_ready", ifu_ready_o ^ lsu_ready_o, 1);
                if (ifu_ready_o)
                    chk("rnd_ifu_payload", {mem_addr_o, mem_wdata_o, mem_wmask_o},
                        {ifu_addr_i, 32'h0, 4'h0});
                else
                    chk("rnd_lsu_payload", {mem_addr_o, mem_wdata_o, mem_wmask_o},
                        {lsu_addr_i, lsu_wdata_i, lsu_wmask_i});
            end else begin
                chk("rnd_no_stray_ready", {ifu_ready_o, lsu_ready_o}, 0);
            end
            if (mem_rvalid_i && mon_out > 0) mon_out--;
            if (mem_valid_o && mem_ready_i) mon_out++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset and a lone LSU write.
        do_reset();
        #1 chk("t1_idle_after_reset", all_outs(), 0);
        @(negedge clk_i);
        lsu_valid_i = 1; lsu_addr_i = 32'h100; lsu_wdata_i = 32'hDEADBEEF; lsu_wmask_i = 4'hF;
        #1 chk("t1_not_same_cycle", mem_valid_o, 0);
        @(negedge clk_i);
        #1 chk("t1_issue_payload", {mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o},
               {1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
        chk("t1_no_ready_yet", lsu_ready_o, 0);
        @(negedge clk_i);
        #1 chk("t1_still_issue", mem_valid_o, 1);
        @(negedge clk_i);
        mem_ready_i = 1;
        #1 chk("t1_ready", {lsu_ready_o, ifu_ready_o}, 2'b10);
        @(negedge clk_i);
        mem_ready_i = 0; lsu_valid_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE0001;
        #1 chk("t1_resp", {lsu_rvalid_o, lsu_rdata_o, ifu_rvalid_o, ifu_rdata_o, mem_valid_o},
               {1'b1, 32'hCAFE0001, 1'b0, 32'h0, 1'b0});
        @(negedge clk_i);
        mem_rvalid_i = 0; mem_rdata_i = 0;
        #1 chk("t1_back_idle", {mem_valid_o, lsu_rvalid_o, err_o}, 0);

        // Tie after reset: LSU, IFU, LSU, IFU with no bubbles.
        do_reset();
        @(negedge clk_i);
        ifu_valid_i = 1; ifu_addr_i = 32'h4;
        lsu_valid_i = 1; lsu_addr_i = 32'h80; lsu_wdata_i = 0; lsu_wmask_i = 0;
        @(negedge clk_i);
        for (int k = 0; k < 4; k++) begin
            logic exp_lsu;
            logic [31:0] rd;
            exp_lsu = (k % 2 == 0);
            rd = exp_lsu ? 32'hA0 + 32'(k) : 32'h13;
            mem_ready_i = 1;
            #1 chk("t2_issue_addr", {mem_valid_o, mem_addr_o}, {1'b1, exp_lsu ? 32'h80 : 32'h4});
            chk("t2_ready_owner", {lsu_ready_o, ifu_ready_o}, {exp_lsu, ~exp_lsu});
            @(negedge clk_i);
            mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = rd;
            if (k == 3) begin ifu_valid_i = 0; lsu_valid_i = 0; end
            #1 chk("t2_route", {ifu_rvalid_o, ifu_rdata_o, lsu_rvalid_o, lsu_rdata_o},
                   {~exp_lsu, exp_lsu ? 32'h0 : rd, exp_lsu, exp_lsu ? rd : 32'h0});
            @(negedge clk_i);
            mem_rvalid_i = 0; mem_rdata_i = 0;
            #1 chk("t2_no_bubble", mem_valid_o, (k < 3));
        end

        // Stray response in Idle.
        @(negedge clk_i);
        mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        #1 chk("t4_no_route", {ifu_rvalid_o, lsu_rvalid_o, ifu_rdata_o, lsu_rdata_o}, 0);
        chk("t4_err_not_yet", err_o, 0);
        @(negedge clk_i);
        mem_rvalid_i = 0; mem_rdata_i = 0;
        #1 chk("t4_err_set", err_o, 1);
        repeat (5) @(negedge clk_i);
        #1 chk("t4_err_sticky", err_o, 1);

        // Reset during WaitResp, late response, then a clean IFU read.
        @(negedge clk_i);
        ifu_valid_i = 1; ifu_addr_i = 32'h40;
        @(negedge clk_i);
        mem_ready_i = 1;
        #1 chk("t5_ifu_ready", ifu_ready_o, 1);
        @(negedge clk_i);
        mem_ready_i = 0; ifu_valid_i = 0; rst_ni = 0;
        #1 chk("t5_reset_outputs_zero", all_outs(), 0);
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
        mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        #1 chk("t5_late_no_route", {ifu_rvalid_o, ifu_rdata_o}, 0);
        @(negedge clk_i);
        mem_rvalid_i = 0; mem_rdata_i = 0; ifu_valid_i = 1; ifu_addr_i = 32'h44;
        #1 chk("t5_late_err", err_o, 1);
        @(negedge clk_i);
        mem_ready_i = 1;
        #1 chk("t5_new_issue", {mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o, ifu_ready_o},
               {1'b1, 32'h44, 32'h0, 4'h0, 1'b1});
        @(negedge clk_i);
        mem_ready_i = 0; ifu_valid_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234;
        #1 chk("t5_new_resp", {ifu_rvalid_o, ifu_rdata_o, lsu_rvalid_o}, {1'b1, 32'h1234, 1'b0});
        @(negedge clk_i);
        mem_rvalid_i = 0; mem_rdata_i = 0;

        // Long memory stall while LSU withdraws and changes its inputs.
        do_reset();
        @(negedge clk_i);
        lsu_valid_i = 1; lsu_addr_i = 32'h200; lsu_wdata_i = 32'h11223344; lsu_wmask_i = 4'h3;
        @(negedge clk_i);
        lsu_valid_i = 0; lsu_addr_i = 32'hFFFF_FFF0; lsu_wdata_i = 0; lsu_wmask_i = 4'hC;
        for (int i = 0; i < 10; i++) begin
            #1 chk("t6_stable_payload", {mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o},
                   {1'b1, 32'h200, 32'h11223344, 4'h3});
            chk("t6_no_ready", lsu_ready_o, 0);
            @(negedge clk_i);
        end
        mem_ready_i = 1;
        #1 chk("t6_ready", {lsu_ready_o, ifu_ready_o}, 2'b10);
        @(negedge clk_i);
        mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBEEF;
        #1 chk("t6_resp", {lsu_rvalid_o, lsu_rdata_o, ifu_rvalid_o}, {1'b1, 32'hBEEF, 1'b0});
        @(negedge clk_i);
        mem_rvalid_i = 0; mem_rdata_i = 0; lsu_addr_i = 0; lsu_wmask_i = 0;

        // Randomised traffic against the scoreboard.
        do_reset();
        mon_out = 0;
        rand_on = 1'b1;
        fork
            begin
                fork
                    drive_ifu(30);
                    drive_lsu(30);
                join
                for (int i = 0; i < 100; i++) begin
                    if (ifu_q.size() == 0 && lsu_q.size() == 0) break;
                    @(negedge clk_i);
                end
                rand_done = 1'b1;
            end
            mem_model();
        join
        repeat (2) @(negedge clk_i);
        rand_on = 1'b0;
        #3;
        chk("rnd_drained", ifu_q.size() + lsu_q.size(), 0);
        chk("rnd_no_err", err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
